// File: rtl/host_snapshot_if.sv
// Host snapshot port bundle: collider sample stream in, host readback and frame status out.
interface host_snapshot_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
);
  logic                         in_collision_state;
  logic                         sample_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] sample_data;
  logic                         host_lock;
  logic [ADDR_WIDTH-1:0]        host_addr;
  logic [NUM_CH*DATA_WIDTH-1:0] host_data;
  logic                         host_data_valid;
  logic                         addr_err;
  logic                         frame_ready;
  logic [ADDR_WIDTH:0]          frame_len;
  logic [15:0]                  frame_count;
  logic                         frame_overflow;
  logic [7:0]                   frames_dropped;

  modport master (
    output in_collision_state, sample_valid, sample_data, host_lock, host_addr,
    input  host_data, host_data_valid, addr_err, frame_ready, frame_len,
           frame_count, frame_overflow, frames_dropped
  );

  modport slave (
    input  in_collision_state, sample_valid, sample_data, host_lock, host_addr,
    output host_data, host_data_valid, addr_err, frame_ready, frame_len,
           frame_count, frame_overflow, frames_dropped
  );
endinterface

// File: rtl/host_snapshot_buffer.sv
// Double-buffered per-cell snapshot capture: one bank fills during a collision stage
// while the host reads the last committed frame from the other bank.
module host_snapshot_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  host_snapshot_if.slave bus
);
  localparam int SW = NUM_CH * DATA_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT, PENDING} state_t;

  state_t          state;
  logic            col_prev;
  logic            lock_prev;
  logic            wr_bank;
  logic            rd_bank;
  logic            cap_ovf;
  logic [PW-1:0]   wptr;
  logic            ready;
  logic [PW-1:0]   len;
  logic [15:0]     count;
  logic            ovf_flag;
  logic [7:0]      dropped;

  logic [SW-1:0]   mem0 [DEPTH];
  logic [SW-1:0]   mem1 [DEPTH];

  logic [SW-1:0]   rd_data_p1;
  logic            vld_p1;
  logic            rd_err_p1;

  logic            col_rise;
  logic            col_fall;
  logic            lock_rise;
  logic            start;
  logic            swap;
  logic            wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [SW-1:0]   rd_word;

  // A rise while a frame is pending and locked restarts capture into the same bank.
  always_comb begin
    col_rise  = bus.in_collision_state & ~col_prev;
    col_fall  = ~bus.in_collision_state & col_prev;
    lock_rise = bus.host_lock & ~lock_prev;
    start     = col_rise && (state == IDLE || (state == PENDING && bus.host_lock));
    swap      = (state == COMMIT || state == PENDING) && !bus.host_lock;
    wr_en     = bus.sample_valid && (start || (state == CAPTURE && wptr < FULL));
    wr_addr   = start ? '0 : wptr[ADDR_WIDTH-1:0];
    rd_word   = rd_bank ? mem1[bus.host_addr] : mem0[bus.host_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      col_prev  <= 1'b0;
      lock_prev <= 1'b0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b1;
      cap_ovf   <= 1'b0;
      wptr      <= '0;
      ready     <= 1'b0;
      len       <= '0;
      count     <= '0;
      ovf_flag  <= 1'b0;
      dropped   <= '0;
    end else begin
      col_prev  <= bus.in_collision_state;
      lock_prev <= bus.host_lock;

      if (start) begin
        wptr    <= {{ADDR_WIDTH{1'b0}}, bus.sample_valid};
        cap_ovf <= 1'b0;
      end else if (state == CAPTURE && bus.sample_valid) begin
        if (wptr < FULL) wptr <= wptr + PW'(1);
        else             cap_ovf <= 1'b1;
      end

      case (state)
        IDLE:    if (start) state <= CAPTURE;
        CAPTURE: if (col_fall) state <= COMMIT;
        COMMIT:  state <= swap ? IDLE : PENDING;
        PENDING: begin
          if (swap) begin
            state <= IDLE;
          end else if (start) begin
            state <= CAPTURE;
            if (dropped != 8'hFF) dropped <= dropped + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (swap) begin
        rd_bank  <= wr_bank;
        wr_bank  <= ~wr_bank;
        len      <= wptr;
        ovf_flag <= cap_ovf;
        count    <= count + 16'd1;
      end

      // A commit landing on the same edge as a lock rise keeps the frame flagged.
      if (swap)           ready <= 1'b1;
      else if (lock_rise) ready <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) mem1[wr_addr] <= bus.sample_data;
      else         mem0[wr_addr] <= bus.sample_data;
    end
  end

  // Host read stage: one-cycle registered read of the locked bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
      rd_err_p1  <= 1'b0;
    end else if (bus.host_lock) begin
      vld_p1 <= 1'b1;
      if ({1'b0, bus.host_addr} >= len) begin
        rd_data_p1 <= '0;
        rd_err_p1  <= 1'b1;
      end else begin
        rd_data_p1 <= rd_word;
        rd_err_p1  <= 1'b0;
      end
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.host_data       = rd_data_p1;
  assign bus.host_data_valid = vld_p1;
  assign bus.addr_err        = rd_err_p1;
  assign bus.frame_ready     = ready;
  assign bus.frame_len       = len;
  assign bus.frame_count     = count;
  assign bus.frame_overflow  = ovf_flag;
  assign bus.frames_dropped  = dropped;
endmodule

// File: tb/tb_host_snapshot_buffer.sv
// Bench for host_snapshot_buffer: directed frame scenarios plus random stages,
// checked every cycle against a frame-level model built from queues.
module tb_host_snapshot_buffer;
  localparam int DW = 16;
  localparam int NC = 4;
  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);
  localparam int SW = DW * NC;
  localparam int PH_IDLE = 0, PH_CAP = 1, PH_COMMIT = 2, PH_PEND = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  host_snapshot_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DEPTH)) bus ();

  host_snapshot_buffer #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Frame-level model: current capture and committed frame kept as sample queues.
  logic [SW-1:0] m_cur[$];
  logic [SW-1:0] m_rd[$];
  int            m_phase, m_len, m_dropped;
  logic [15:0]   m_count;
  bit            m_ovf, m_fovf, m_ready, m_hv, m_aerr, m_col_prev, m_lock_prev;
  logic [SW-1:0] m_hd;

  task automatic mreset();
    m_cur.delete(); m_rd.delete();
    m_phase = PH_IDLE; m_len = 0; m_dropped = 0; m_count = '0;
    m_ovf = 0; m_fovf = 0; m_ready = 0; m_hv = 0; m_aerr = 0;
    m_col_prev = 0; m_lock_prev = 0; m_hd = '0;
  endtask

  task automatic mstep();
    bit col, lock, sv, rise, fall, lrise, capt, swap;
    int addr;
    col = bus.in_collision_state; lock = bus.host_lock; sv = bus.sample_valid;
    rise = col && !m_col_prev; fall = !col && m_col_prev; lrise = lock && !m_lock_prev;
    capt = 0; swap = 0;
    addr = int'(bus.host_addr);
    if (lock) begin
      m_hv = 1;
      if (addr >= m_len) begin m_hd = '0; m_aerr = 1; end
      else begin m_hd = m_rd[addr]; m_aerr = 0; end
    end else m_hv = 0;
    case (m_phase)
      PH_IDLE: if (rise) begin m_phase = PH_CAP; m_cur.delete(); m_ovf = 0; capt = 1; end
      PH_CAP: begin capt = 1; if (fall) m_phase = PH_COMMIT; end
      PH_COMMIT: if (!lock) begin swap = 1; m_phase = PH_IDLE; end else m_phase = PH_PEND;
      default: begin
        if (!lock) begin swap = 1; m_phase = PH_IDLE; end
        else if (rise) begin
          if (m_dropped != 255) m_dropped++;
          m_cur.delete(); m_ovf = 0; capt = 1; m_phase = PH_CAP;
        end
      end
    endcase
    if (capt && sv) begin
      if (m_cur.size() < DEPTH) m_cur.push_back(bus.sample_data);
      else m_ovf = 1;
    end
    if (swap) begin
      m_rd = m_cur; m_len = m_cur.size(); m_fovf = m_ovf; m_count++; m_ready = 1;
    end else if (lrise) m_ready = 0;
    m_col_prev = col; m_lock_prev = lock;
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) mreset();
      else mstep();
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("host_data", bus.host_data, m_hd);
        chk("host_data_valid", bus.host_data_valid, m_hv);
        chk("addr_err", bus.addr_err, m_aerr);
        chk("frame_ready", bus.frame_ready, m_ready);
        chk("frame_len", bus.frame_len, m_len);
        chk("frame_count", bus.frame_count, m_count);
        chk("frame_overflow", bus.frame_overflow, m_fovf);
        chk("frames_dropped", bus.frames_dropped, m_dropped);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rand_host();
    if ($urandom_range(0, 7) == 0) bus.host_lock = ~bus.host_lock;
    bus.host_addr = AW'($urandom_range(0, DEPTH - 1));
  endtask

  task automatic drive_sample(bit valid, int idx);
    logic [SW-1:0] d;
    d = {$urandom(), $urandom()};
    d[15:0] = 16'(idx);
    bus.sample_valid = valid;
    bus.sample_data = d;
  endtask

  // ch0 of each sample carries its index within the stage.
  task automatic stage(int ncyc, bit rnd, int gap);
    int idx = 0;
    bit v;
    for (int c = 0; c < ncyc; c++) begin
      bus.in_collision_state = 1'b1;
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive_sample(v, idx);
      if (v) idx++;
      if (rnd) rand_host();
      tick();
    end
    bus.in_collision_state = 1'b0;
    bus.sample_valid = 1'b0;
    if (rnd) rand_host();
    tick();
    for (int g = 0; g < gap; g++) begin
      if (rnd) begin drive_sample($urandom_range(0, 1) == 1, 99); rand_host(); end
      tick();
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic chk_all_zero();
    chk("rst_host_data", bus.host_data, 0);
    chk("rst_valid", bus.host_data_valid, 0);
    chk("rst_addr_err", bus.addr_err, 0);
    chk("rst_frame_ready", bus.frame_ready, 0);
    chk("rst_frame_len", bus.frame_len, 0);
    chk("rst_frame_count", bus.frame_count, 0);
    chk("rst_overflow", bus.frame_overflow, 0);
    chk("rst_dropped", bus.frames_dropped, 0);
  endtask

  initial begin
    bus.in_collision_state = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data = '0;
    bus.host_lock = 1'b0;
    bus.host_addr = '0;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    cmp_en = 1;
    chk_all_zero();

    // Ten-sample frame committed with the host unlocked, then read back.
    stage(10, 0, 3);
    chk("lit_ready", bus.frame_ready, 1);
    chk("lit_len10", bus.frame_len, 10);
    chk("lit_count1", bus.frame_count, 1);
    bus.host_lock = 1'b1; bus.host_addr = AW'(3);
    tick();
    chk("lit_rd3", bus.host_data[15:0], 3);
    chk("lit_rd3_valid", bus.host_data_valid, 1);
    chk("lit_ready_clr", bus.frame_ready, 0);
    bus.host_addr = AW'(12);
    tick();
    chk("lit_oob_data", bus.host_data, 0);
    chk("lit_oob_err", bus.addr_err, 1);

    // Overflowing stage.
    bus.host_lock = 1'b0; bus.host_addr = '0;
    tick();
    stage(DEPTH + 5, 0, 3);
    chk("lit_ovf_len", bus.frame_len, DEPTH);
    chk("lit_ovf_flag", bus.frame_overflow, 1);
    bus.host_lock = 1'b1; bus.host_addr = AW'(DEPTH - 1);
    tick();
    chk("lit_last_entry", bus.host_data[15:0], DEPTH - 1);

    // Locked across collision end: commit waits for unlock.
    stage(4, 0, 3);
    chk("lit_locked_count", bus.frame_count, 2);
    chk("lit_locked_data", bus.host_data[15:0], DEPTH - 1);
    bus.host_lock = 1'b0;
    tick();
    chk("lit_unlock_count", bus.frame_count, 3);
    chk("lit_unlock_len", bus.frame_len, 4);

    // Locked through stage N end and stage N+1 start: stage N is dropped.
    bus.host_lock = 1'b1;
    tick();
    stage(3, 0, 3);
    stage(6, 0, 3);
    chk("lit_dropped", bus.frames_dropped, 1);
    chk("lit_drop_count", bus.frame_count, 3);
    bus.host_lock = 1'b0;
    tick();
    chk("lit_n1_len", bus.frame_len, 6);
    chk("lit_n1_count", bus.frame_count, 4);

    // Asynchronous reset in the middle of a capture.
    for (int i = 0; i < 5; i++) begin
      bus.in_collision_state = 1'b1; drive_sample(1'b1, i); tick();
    end
    #2 rst = 1'b0;
    #1 chk_all_zero();
    tick();
    bus.in_collision_state = 1'b0; bus.sample_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    stage(7, 0, 3);
    chk("lit_post_rst_len", bus.frame_len, 7);
    chk("lit_post_rst_count", bus.frame_count, 1);

    // Random stages with host lock and address wandering.
    for (int s = 0; s < 60; s++) stage($urandom_range(0, DEPTH + 4), 1, $urandom_range(2, 6));
    bus.host_lock = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
